alu_result_decryptor: RTL

Receive-side counterpart of the always-encrypted 8-bit ALU: accepts an encrypted ALU result plus the 8-bit key and recovers the plaintext ALU result. It sits on the consumer side of the ALU (debug readback, host link), undoing one SPN round per clock under a valid/ready handshake. An opcode tag rides alongside the data for result attribution.

---
 rtl/alu_crypto_pkg.sv | 64 ++++++
 rtl/alu_result_decryptor_if.sv | 22 ++
 rtl/alu_result_decryptor_inv_round.sv | 12 +
 rtl/alu_result_decryptor.sv | 94 +++++++++
 4 files changed

// File: rtl/alu_crypto_pkg.sv
// Shared SPN primitives for the always-encrypted ALU: S-boxes, bit permutations,
// round-key derivation and the decryptor FSM state type.
package alu_crypto_pkg;

    localparam logic [7:0] RK2_CONST = 8'h3C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UNDO2,
        ST_UNDO1,
        ST_HOLD
    } dec_state_e;

    // Transaction context captured on input handshake; data is rewritten per round.
    typedef struct packed {
        logic [7:0] data;
        logic [7:0] key;
        logic [3:0] tag;
    } dec_ctx_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h5;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hB;
            4'h4: sbox4 = 4'h9;  4'h5: sbox4 = 4'h0;  4'h6: sbox4 = 4'hA;  4'h7: sbox4 = 4'hD;
            4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'hE;  4'hA: sbox4 = 4'hF;  4'hB: sbox4 = 4'h8;
            4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'h7;  4'hE: sbox4 = 4'h1;  default: sbox4 = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] invsbox4(input logic [3:0] x);
        case (x)
            4'h0: invsbox4 = 4'h5;  4'h1: invsbox4 = 4'hE;  4'h2: invsbox4 = 4'hF;  4'h3: invsbox4 = 4'h8;
            4'h4: invsbox4 = 4'hC;  4'h5: invsbox4 = 4'h1;  4'h6: invsbox4 = 4'h2;  4'h7: invsbox4 = 4'hD;
            4'h8: invsbox4 = 4'hB;  4'h9: invsbox4 = 4'h4;  4'hA: invsbox4 = 4'h6;  4'hB: invsbox4 = 4'h3;
            4'hC: invsbox4 = 4'h0;  4'hD: invsbox4 = 4'h7;  4'hE: invsbox4 = 4'h9;  default: invsbox4 = 4'hA;
        endcase
    endfunction

    function automatic logic [7:0] sbox8(input logic [7:0] x);
        return {sbox4(x[7:4]), sbox4(x[3:0])};
    endfunction

    function automatic logic [7:0] invsbox8(input logic [7:0] x);
        return {invsbox4(x[7:4]), invsbox4(x[3:0])};
    endfunction

    function automatic logic [7:0] perm8(input logic [7:0] x);
        return {x[0], x[2], x[4], x[6], x[1], x[3], x[5], x[7]};
    endfunction

    function automatic logic [7:0] invperm8(input logic [7:0] x);
        return {x[0], x[4], x[1], x[5], x[2], x[6], x[3], x[7]};
    endfunction

    // k0 equals the key itself and cancels against the OTP XOR, so only k1/k2 exist.
    function automatic logic [7:0] round_key1(input logic [7:0] key);
        return {key[3:0], key[7:4]};
    endfunction

    function automatic logic [7:0] round_key2(input logic [7:0] key);
        return key ^ RK2_CONST;
    endfunction

endpackage

// File: rtl/alu_result_decryptor_if.sv
// Valid/ready bus of the ALU result decryptor: cipher/key/tag in, plaintext/tag out.
interface alu_result_decryptor_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] cipher_in;
    logic [7:0] key_in;
    logic [3:0] tag_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] plain_out;
    logic [3:0] tag_out;

    modport master (
        output in_valid, cipher_in, key_in, tag_in, out_ready,
        input  in_ready, out_valid, plain_out, tag_out
    );

    modport slave (
        input  in_valid, cipher_in, key_in, tag_in, out_ready,
        output in_ready, out_valid, plain_out, tag_out
    );
endinterface

// File: rtl/alu_result_decryptor_inv_round.sv
// One combinational inverse SPN round: y = invsbox8(invperm8(x ^ rk)).
module spn_inv_round
    import alu_crypto_pkg::*;
(
    input  logic [7:0] x,
    input  logic [7:0] rk,
    output logic [7:0] y
);

    assign y = invsbox8(invperm8(x ^ rk));

endmodule

// File: rtl/alu_result_decryptor.sv
// Decrypts an 8-bit ALU result over two clocked inverse rounds under valid/ready.
// Optional completed-transaction counter enabled by defining ALU_DEC_STATS_EN.
module alu_result_decryptor
    import alu_crypto_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    alu_result_decryptor_if.slave bus,
    output logic [15:0]           dec_count
);

    dec_state_e state_q, state_d;
    dec_ctx_t   ctx_q, ctx_d;
    logic [7:0] round_key;
    logic [7:0] round_out;
    logic       out_fire;

    // Round keys come from the captured key so the source may change key_in freely.
    assign round_key = (state_q == ST_UNDO1) ? round_key1(ctx_q.key) : round_key2(ctx_q.key);

    spn_inv_round u_inv_round (
        .x  (ctx_q.data),
        .rk (round_key),
        .y  (round_out)
    );

    assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign out_fire      = bus.out_valid && bus.out_ready;

    // Intermediate round state never leaks onto the result bus.
    assign bus.plain_out = bus.out_valid ? ctx_q.data : 8'h00;
    assign bus.tag_out   = bus.out_valid ? ctx_q.tag  : 4'h0;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d = state_q;
        ctx_d   = ctx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    ctx_d.data = bus.cipher_in;
                    ctx_d.key  = bus.key_in;
                    ctx_d.tag  = bus.tag_in;
                    state_d    = ST_UNDO2;
                end
            end
            ST_UNDO2: begin
                ctx_d.data = round_out;
                state_d    = ST_UNDO1;
            end
            ST_UNDO1: begin
                ctx_d.data = round_out;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            ctx_q   <= '0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
        end
    end

`ifdef ALU_DEC_STATS_EN
    logic [15:0] dec_count_q, dec_count_d;

    always_comb begin
        dec_count_d = dec_count_q;
        if (out_fire && (dec_count_q != 16'hFFFF)) dec_count_d = dec_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) dec_count_q <= '0;
        else     dec_count_q <= dec_count_d;
    end

    assign dec_count = dec_count_q;
`else
    logic unused_fire;
    assign unused_fire = out_fire;
    assign dec_count   = 16'h0000;
`endif

endmodule
